// File: rtl/f2i.sv
// f2i: IEEE 754 float to signed/unsigned integer converter.
// Three clock-enabled stages: unpack, align, round/saturate.
module f2i #(
    parameter int FPWID = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             ld,
    input  logic             op,
    input  logic [2:0]       rm,
    input  logic [FPWID-1:0] i,
    output logic [FPWID-1:0] o,
    output logic             done,
    output logic             overflow,
    output logic             invalid,
    output logic             inexact
);

    localparam int EMSB = (FPWID == 64) ? 10 : 7;
    localparam int FMSB = (FPWID == 64) ? 51 : 22;
    localparam int BIAS = (1 << EMSB) - 1;
    localparam int XW   = EMSB + 2;
    localparam int MW   = FMSB + 2;
    // fraction bits kept below the binary point while aligning
    localparam int FB   = FMSB + 2;
    localparam int PW   = FPWID + FB;

    localparam logic [FPWID:0]   HALF = (FPWID+1)'(1) << (FPWID-1);
    localparam logic [FPWID-1:0] MAXP = {1'b0, {(FPWID-1){1'b1}}};
    localparam logic [FPWID-1:0] MINN = {1'b1, {(FPWID-1){1'b0}}};

    // stage 1 state
    logic          v1_q, v1_d;
    logic          s1_q, s1_d;
    logic          nan1_q, nan1_d;
    logic          inf1_q, inf1_d;
    logic          tiny1_q, tiny1_d;
    logic          op1_q, op1_d;
    logic [2:0]    rm1_q, rm1_d;
    logic [MW-1:0] m1_q, m1_d;
    logic [XW-1:0] x1_q, x1_d;

    // stage 2 state
    logic             v2_q, v2_d;
    logic             s2_q, s2_d;
    logic             nan2_q, nan2_d;
    logic             tiny2_q, tiny2_d;
    logic             op2_q, op2_d;
    logic [2:0]       rm2_q, rm2_d;
    logic [FPWID-1:0] int2_q, int2_d;
    logic             r2_q, r2_d;
    logic             st2_q, st2_d;
    logic             pre2_q, pre2_d;

    // output stage state
    logic [FPWID-1:0] o_q, o_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;
    logic             inx_q, inx_d;

    logic [EMSB:0]   e_in;
    logic [FMSB:0]   f_in;
    logic [XW-1:0]   sh;
    logic            xneg;
    logic            xbig;
    logic [PW-1:0]   p;
    logic            inc;
    logic [FPWID:0]  mag;

    assign e_in = i[FPWID-2:FMSB+1];
    assign f_in = i[FMSB:0];

    // Stage 1: split fields, classify, remove the exponent bias
    always_comb begin
        v1_d    = v1_q;
        s1_d    = s1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        tiny1_d = tiny1_q;
        op1_d   = op1_q;
        rm1_d   = rm1_q;
        m1_d    = m1_q;
        x1_d    = x1_q;
        if (ce) begin
            v1_d    = ld;
            s1_d    = i[FPWID-1];
            nan1_d  = (&e_in) & (|f_in);
            inf1_d  = (&e_in) & ~(|f_in);
            tiny1_d = ~(|e_in);
            op1_d   = op;
            rm1_d   = rm;
            m1_d    = {|e_in, f_in};
            x1_d    = {1'b0, e_in} - XW'(BIAS);
        end
    end

    // Stage 2: place the mantissa on a fixed-point grid, pick off r/sticky
    always_comb begin
        sh   = x1_q + XW'(1);
        xneg = x1_q[XW-1];
        xbig = ~xneg & (x1_q >= XW'(FPWID));
        p    = '0;
        if (~xneg & ~xbig)
            p = PW'(m1_q) << sh;
        else if (&x1_q)
            p = PW'(m1_q);

        v2_d    = v2_q;
        s2_d    = s2_q;
        nan2_d  = nan2_q;
        tiny2_d = tiny2_q;
        op2_d   = op2_q;
        rm2_d   = rm2_q;
        int2_d  = int2_q;
        r2_d    = r2_q;
        st2_d   = st2_q;
        pre2_d  = pre2_q;
        if (ce) begin
            v2_d    = v1_q;
            s2_d    = s1_q;
            nan2_d  = nan1_q;
            tiny2_d = tiny1_q;
            op2_d   = op1_q;
            rm2_d   = rm1_q;
            pre2_d  = xbig | inf1_q | nan1_q;
            int2_d  = p[PW-1:FB];
            r2_d    = p[FB-1];
            st2_d   = |p[FB-2:0];
            if (xneg & ~(&x1_q)) begin
                r2_d  = 1'b0;
                st2_d = |m1_q;
            end
        end
    end

    // Stage 3 datapath: rounding increment and widened magnitude
    always_comb begin
        case (rm2_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = (r2_q | st2_q) & ~s2_q;
            3'd3:    inc = (r2_q | st2_q) & s2_q;
            3'd4:    inc = r2_q | st2_q;
            default: inc = r2_q & (int2_q[0] | st2_q);
        endcase
        // zero and denormal inputs always produce zero
        if (tiny2_q)
            inc = 1'b0;
        mag = {1'b0, int2_q} + (FPWID+1)'(inc);
    end

    // Stage 3 control: sign, saturation and flags
    always_comb begin
        o_d    = o_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        inv_d  = inv_q;
        inx_d  = inx_q;
        if (ce) begin
            done_d = v2_q;
            if (v2_q) begin
                ovf_d = 1'b0;
                inv_d = 1'b0;
                o_d   = s2_q ? -mag[FPWID-1:0] : mag[FPWID-1:0];
                if (nan2_q) begin
                    inv_d = 1'b1;
                    o_d   = op2_q ? MAXP : '1;
                end else if (op2_q) begin
                    if (~s2_q & (pre2_q | (mag > HALF - 1'b1))) begin
                        ovf_d = 1'b1;
                        o_d   = MAXP;
                    end else if (s2_q & (pre2_q | (mag > HALF))) begin
                        ovf_d = 1'b1;
                        o_d   = MINN;
                    end
                end else if (s2_q) begin
                    o_d   = '0;
                    inv_d = pre2_q | (|mag);
                end else if (pre2_q | mag[FPWID]) begin
                    ovf_d = 1'b1;
                    o_d   = '1;
                end
                inx_d = (r2_q | st2_q) & ~nan2_q & ~ovf_d;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            tiny1_q <= 1'b0;
            op1_q   <= 1'b0;
            rm1_q   <= '0;
            m1_q    <= '0;
            x1_q    <= '0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            nan2_q  <= 1'b0;
            tiny2_q <= 1'b0;
            op2_q   <= 1'b0;
            rm2_q   <= '0;
            int2_q  <= '0;
            r2_q    <= 1'b0;
            st2_q   <= 1'b0;
            pre2_q  <= 1'b0;
            o_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            tiny1_q <= tiny1_d;
            op1_q   <= op1_d;
            rm1_q   <= rm1_d;
            m1_q    <= m1_d;
            x1_q    <= x1_d;
            v2_q    <= v2_d;
            s2_q    <= s2_d;
            nan2_q  <= nan2_d;
            tiny2_q <= tiny2_d;
            op2_q   <= op2_d;
            rm2_q   <= rm2_d;
            int2_q  <= int2_d;
            r2_q    <= r2_d;
            st2_q   <= st2_d;
            pre2_q  <= pre2_d;
            o_q     <= o_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
        end
    end

    assign o        = o_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign invalid  = inv_q;
    assign inexact  = inx_q;

endmodule

// File: tb/tb_f2i.sv
// tb_f2i: directed and random checks of the float-to-integer converter
// against a real-arithmetic reference model.
module tb_f2i;

    typedef struct packed {
        logic        v;
        logic [31:0] o;
        logic        ovf;
        logic        inv;
        logic        inx;
    } exp_t;

    localparam exp_t NONE = '0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        ld;
    logic        op;
    logic [2:0]  rm;
    logic [31:0] i_in;
    logic [31:0] o;
    logic        done;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    exp_t pipe[$];
    logic last_v;
    int   npass = 0;
    int   nfail = 0;
    int   ntot  = 0;

    f2i #(.FPWID(32)) dut (
        .clk(clk), .rst(rst), .ce(ce), .ld(ld), .op(op), .rm(rm),
        .i(i_in), .o(o), .done(done), .overflow(overflow),
        .invalid(invalid), .inexact(inexact)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] ov, input logic f_ovf,
                                input logic f_inv, input logic f_inx);
        exp_t r;
        r.v = 1'b1; r.o = ov; r.ovf = f_ovf; r.inv = f_inv; r.inx = f_inx;
        return r;
    endfunction

    // Reference: value as a real, integer part and fraction, then the
    // rounding rule and the integer range limits applied arithmetically.
    function automatic exp_t model(input logic [31:0] a, input logic sop,
                                   input logic [2:0] srm);
        exp_t r;
        logic s;
        int e;
        longint f;
        real av, ip, fr, mg;
        logic up, tiny;
        r = mk(32'h0, 1'b0, 1'b0, 1'b0);
        s = a[31];
        e = int'(a[30:23]);
        f = longint'(a[22:0]);
        tiny = (e == 0);
        if (e == 255 && f != 0) begin
            r.inv = 1'b1;
            r.o = sop ? 32'h7fffffff : 32'hffffffff;
            return r;
        end
        if (e == 255) begin
            ip = 2.0 ** 200;
            fr = 0.0;
        end else begin
            if (tiny) av = real'(f) * (2.0 ** -149);
            else av = (real'(f) + 8388608.0) * (2.0 ** real'(e - 150));
            ip = $floor(av);
            fr = av - ip;
        end
        case (srm)
            3'd1: up = 1'b0;
            3'd2: up = (fr > 0.0) && !s;
            3'd3: up = (fr > 0.0) && s;
            3'd4: up = (fr > 0.0);
            default: up = (fr > 0.5) ||
                          (fr == 0.5 && (longint'(ip) % 2 == 1));
        endcase
        if (tiny) up = 1'b0;
        mg = ip + (up ? 1.0 : 0.0);
        if (sop) begin
            if (!s && mg > 2147483647.0) begin
                r.ovf = 1'b1; r.o = 32'h7fffffff;
            end else if (s && mg > 2147483648.0) begin
                r.ovf = 1'b1; r.o = 32'h80000000;
            end else begin
                r.o = s ? 32'(-longint'(mg)) : 32'(longint'(mg));
            end
        end else begin
            if (s) begin
                r.o = 32'h0;
                r.inv = (mg != 0.0);
            end else if (mg > 4294967295.0) begin
                r.ovf = 1'b1; r.o = 32'hffffffff;
            end else begin
                r.o = 32'(longint'(mg));
            end
        end
        r.inx = (fr != 0.0) && !r.ovf;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] ex);
        ntot++;
        assert (obs === ex) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    // One clock: drive inputs, then check outputs 1 time unit after the edge
    task automatic cyc(input logic c, input logic l, input logic [31:0] a,
                       input logic p, input logic [2:0] r, input exp_t ex);
        exp_t got;
        ce = c; ld = l; i_in = a; op = p; rm = r;
        @(posedge clk);
        #1;
        if (c) begin
            pipe.push_back(l ? ex : NONE);
            got = pipe.pop_front();
            last_v = got.v;
            chk("done", {31'b0, done}, {31'b0, got.v});
            if (got.v) begin
                chk("o", o, got.o);
                chk("overflow", {31'b0, overflow}, {31'b0, got.ovf});
                chk("invalid", {31'b0, invalid}, {31'b0, got.inv});
                chk("inexact", {31'b0, inexact}, {31'b0, got.inx});
            end
        end else begin
            chk("done_frozen", {31'b0, done}, {31'b0, last_v});
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic p,
                         input logic [2:0] r, input exp_t ex);
        cyc(1'b1, 1'b1, a, p, r, ex);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 3'd0, NONE);
    endtask

    initial begin
        logic [31:0] a;
        logic        c, l, p;
        logic [2:0]  r;
        rst = 1'b1; ce = 1'b0; ld = 1'b0; op = 1'b0; rm = 3'd0; i_in = '0;
        last_v = 1'b0;
        pipe = {NONE, NONE};
        #12;
        chk("rst_o", o, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_flags", {29'b0, overflow, invalid, inexact}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        issue(32'h40600000, 1'b1, 3'd0, mk(32'd4, 1'b0, 1'b0, 1'b1));
        idle(3);
        issue(32'h40200000, 1'b1, 3'd0, mk(32'd2, 1'b0, 1'b0, 1'b1));
        issue(32'h40200000, 1'b1, 3'd4, mk(32'd3, 1'b0, 1'b0, 1'b1));
        issue(32'h40200000, 1'b1, 3'd1, mk(32'd2, 1'b0, 1'b0, 1'b1));
        issue(32'hBFC00000, 1'b1, 3'd3, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b1));
        issue(32'hBFC00000, 1'b1, 3'd2, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
        issue(32'hBFC00000, 1'b1, 3'd0, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b1));
        issue(32'h4F000000, 1'b1, 3'd0, mk(32'h7FFFFFFF, 1'b1, 1'b0, 1'b0));
        issue(32'h4F000000, 1'b0, 3'd0, mk(32'h80000000, 1'b0, 1'b0, 1'b0));
        issue(32'hCF000000, 1'b1, 3'd0, mk(32'h80000000, 1'b0, 1'b0, 1'b0));
        issue(32'h4F800000, 1'b0, 3'd0, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
        issue(32'h7FC00000, 1'b1, 3'd0, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0));
        issue(32'hBF800000, 1'b0, 3'd0, mk(32'h0, 1'b0, 1'b1, 1'b0));
        issue(32'hBE99999A, 1'b0, 3'd0, mk(32'h0, 1'b0, 1'b0, 1'b1));
        issue(32'h7F800000, 1'b1, 3'd0, mk(32'h7FFFFFFF, 1'b1, 1'b0, 1'b0));
        issue(32'h00000000, 1'b1, 3'd0, mk(32'h0, 1'b0, 1'b0, 1'b0));
        issue(32'h00000001, 1'b1, 3'd2, mk(32'h0, 1'b0, 1'b0, 1'b1));
        idle(3);

        // ce low freezes everything and ignores ld
        issue(32'h40600000, 1'b1, 3'd0, mk(32'd4, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b1, 32'h3F800000, 1'b1, 3'd0, NONE);
        idle(3);

        // reset with two conversions in flight
        issue(32'h40600000, 1'b1, 3'd0, NONE);
        issue(32'h40200000, 1'b1, 3'd0, NONE);
        rst = 1'b1;
        #1;
        chk("midrst_o", o, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_flags", {29'b0, overflow, invalid, inexact}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pipe = {NONE, NONE};
        last_v = 1'b0;
        idle(4);

        // random traffic with random ce/ld gaps
        for (int n = 0; n < 600; n++) begin
            c = ($urandom % 8) != 0;
            l = ($urandom % 4) != 0;
            p = $urandom % 2;
            r = 3'($urandom % 8);
            if ($urandom % 4 == 0) a = $urandom;
            else a = {1'($urandom % 2), 8'($urandom_range(110, 165)),
                      23'($urandom)};
            cyc(c, l, a, p, r, model(a, p, r));
        end
        idle(3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/f2i.md
Name: f2i

Overview:
- Converts an IEEE 754 binary float of width FPWID into a FPWID-bit signed or unsigned integer.
- It is the reverse-direction companion of the integer-to-float converter in the fp unit and uses the same rm encoding and the same fp package field layout.
- Fully pipelined, 3 clock-enabled stages, one conversion accepted per enabled cycle.
- Saturates results that are out of range and reports exception flags.

Parameters:
- FPWID, 32, float and integer width. Supported values: 32 and 64.
- EMSB, FMSB: derived from the fp package, not overridable.
  - FPWID=32: EMSB=7, FMSB=22, bias 127.
  - FPWID=64: EMSB=10, FMSB=51, bias 1023.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; the pipeline advances only when ce=1
- ld  in  1  input valid; sampled only when ce=1
- op  in  1  1 = signed result, 0 = unsigned result
- rm  in  3  rounding mode
- i  in  FPWID  float input
- o  out  FPWID  integer result
- done  out  1  o and the flags are valid this cycle
- overflow  out  1  finite or infinite value out of range; result saturated
- invalid  out  1  NaN input, or unsigned conversion of a negative value that rounds to a nonzero magnitude
- inexact  out  1  a nonzero fraction was discarded

Behaviour:
- Reset: every pipeline register and valid bit clears asynchronously. o=0, done=0, overflow=0, invalid=0, inexact=0.
- Latency: the result appears 3 ce-enabled cycles after ld is sampled. done follows ld through the same 3 stages.
- ce=0 freezes all stages, outputs included. ld is ignored while ce=0.
- Back-to-back ld on consecutive enabled cycles is legal. There is no backpressure.
- Stage 1, unpack and classify:
  - sign s, exponent e, fraction f. Hidden bit = |e; denormals get hidden 0.
  - Unbiased exponent x = e - bias, signed, EMSB+2 bits.
  - Flags: isnan (e all ones, f != 0), isinf (e all ones, f == 0), iszero.
  - Registered along with op and rm.
- Stage 2, align:
  - Mantissa m = {hidden, f}.
  - If x < 0: integer part = 0, rnd bit r = (x == -1) ? hidden : 0, sticky = remaining bits nonzero.
  - If 0 <= x <= FMSB+1: right-shift m by FMSB+1-x. The shifted-out MSB is r; the OR of the rest is sticky.
  - Otherwise: left-shift m by x-FMSB-1. Then r=0, sticky=0.
  - Pre-overflow when x >= FPWID (magnitude does not fit FPWID bits).
  - g = integer lsb.
- Stage 3, round, negate, saturate:
  - Rounding increment:
    - rm=0: r & (g | sticky), nearest even
    - rm=1: 0, truncate
    - rm=2: (r | sticky) & ~s, toward +inf
    - rm=3: (r | sticky) & s, toward -inf
    - rm=4: r | sticky, away from zero
    - rm=5..7: same as rm=0
  - Magnitude is summed FPWID+1 bits wide so a round-up carry is detected.
  - inexact = (r | sticky) & ~isnan & ~overflow.
  - Signed (op=1) limits:
    - positive magnitude > 2^(FPWID-1)-1: overflow, o = 2^(FPWID-1)-1
    - negative magnitude > 2^(FPWID-1): overflow, o = 2^(FPWID-1)
    - magnitude exactly 2^(FPWID-1) with s=1: legal, o = 0x80..0, no flag
  - Unsigned (op=0) limits:
    - magnitude > 2^FPWID-1 with s=0: overflow, o = all ones
    - s=1 and magnitude != 0: invalid, o = 0
    - s=1 and magnitude == 0 (e.g. -0.3): o = 0, not invalid
  - Infinities: +inf gives the positive limit with overflow. -inf gives the negative limit (signed) or 0 with invalid (unsigned).
  - NaN, either sign: o = 2^(FPWID-1)-1 if op=1, all ones if op=0; invalid=1.
  - Otherwise o = s ? -magnitude : magnitude.
  - Zero and denormal inputs give o=0. Denormals set inexact.
- Flags are valid only when done=1. They hold their last value otherwise.
- Reset mid-operation drops every in-flight conversion. No done is produced for them.

Test Plan (FPWID=32):
- i=0x40600000 (3.5), op=1, rm=0, ld with ce=1 -> 3 cycles later done=1, o=4, inexact=1.
- i=0x40200000 (2.5), op=1 -> rm=0 gives o=2; rm=4 gives o=3; rm=1 gives o=2; inexact=1 in each case. Issue on 3 consecutive cycles and check the 3 consecutive done results in order.
- i=0xBFC00000 (-1.5), op=1 -> rm=3 gives o=0xFFFFFFFE; rm=2 gives o=0xFFFFFFFF; rm=0 gives o=0xFFFFFFFE.
- i=0x4F000000 (2^31):
  - op=1 -> o=0x7FFFFFFF, overflow=1.
  - op=0 -> o=0x80000000, overflow=0.
  - i=0xCF000000, op=1 -> o=0x80000000, overflow=0.
  - i=0x4F800000, op=0 -> o=0xFFFFFFFF, overflow=1.
- i=0x7FC00000 (NaN), op=1 -> o=0x7FFFFFFF, invalid=1. i=0xBF800000 (-1.0), op=0 -> o=0, invalid=1. i=0xBE99999A (-0.3), op=0, rm=0 -> o=0, invalid=0, inexact=1.
- ld pulse, then ce=0 for 5 cycles -> done is withheld until the 3rd enabled cycle. Assert rst with 2 conversions in flight -> o=0 and done=0 immediately, and no done follows.
